// File: rtl/mips_core_pkg.sv
// Shared core types: address width, branch outcome encoding, resolver FSM state
// and the in-flight branch record held by the resolver FIFO.
package mips_core_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } ResolverState;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    BranchOutcome          prediction;
    logic [ADDR_WIDTH-1:0] target;
  } BranchEntry;

endpackage

// File: rtl/branch_resolver_fifo.sv
// Program-order store of in-flight branches; flush drops every entry at once.
module branch_resolver_fifo
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  BranchEntry push_entry,
  output BranchEntry head_entry,
  output logic       empty,
  output logic       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  BranchEntry       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occupancy;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Payload is left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head_entry = mem[rd_ptr];
  assign empty      = (occupancy == '0);
  assign full       = (occupancy == OCC_W'(DEPTH));

endmodule

// File: rtl/branch_resolver.sv
// Tracks outstanding conditional branches, trains the predictor on resolution
// and issues a one-cycle redirect with flush on a misprediction.
module branch_resolver
  import mips_core_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push_valid,
  input  logic [ADDR_WIDTH-1:0] i_push_pc,
  input  BranchOutcome          i_push_prediction,
  input  logic [ADDR_WIDTH-1:0] i_push_target,
  output logic                  o_push_ready,
  input  logic                  i_res_valid,
  input  BranchOutcome          i_res_outcome,
  output logic                  o_fb_valid,
  output logic [ADDR_WIDTH-1:0] o_fb_pc,
  output BranchOutcome          o_fb_prediction,
  output BranchOutcome          o_fb_outcome,
  output logic                  o_recover_valid,
  output logic [ADDR_WIDTH-1:0] o_recover_target,
  output logic [CNT_WIDTH-1:0]  o_branch_count,
  output logic [CNT_WIDTH-1:0]  o_mispredict_count,
  output logic                  o_err
);

  ResolverState state;
  BranchEntry   head;
  BranchEntry   push_entry;
  logic         fifo_empty;
  logic         fifo_full;
  logic         in_normal;
  logic         res_fire;
  logic         mispredict;
  logic         res_correct;
  logic         push_fire;
  logic         push_err;
  logic         res_err;

  assign in_normal   = (state == NORMAL);
  assign res_fire    = i_res_valid && in_normal && !fifo_empty;
  assign mispredict  = res_fire && (i_res_outcome != head.prediction);
  assign res_correct = res_fire && !mispredict;

  // A correct resolve frees the head slot this cycle, so a push may ride along
  // even when the FIFO is full.
  assign push_fire = i_push_valid && in_normal && !mispredict && (!fifo_full || res_correct);
  assign push_err  = i_push_valid && in_normal && !mispredict && !push_fire;
  assign res_err   = i_res_valid && (!in_normal || fifo_empty);

  assign o_push_ready = !fifo_full && in_normal;

  assign push_entry = '{pc: i_push_pc, prediction: i_push_prediction, target: i_push_target};

  branch_resolver_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_fire),
    .pop       (res_fire),
    .flush     (mispredict),
    .push_entry(push_entry),
    .head_entry(head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= NORMAL;
      o_fb_valid         <= 1'b0;
      o_fb_pc            <= '0;
      o_fb_prediction    <= NOT_TAKEN;
      o_fb_outcome       <= NOT_TAKEN;
      o_recover_valid    <= 1'b0;
      o_recover_target   <= '0;
      o_branch_count     <= '0;
      o_mispredict_count <= '0;
      o_err              <= 1'b0;
    end else begin
      // RECOVER lasts exactly the cycle the redirect is visible.
      state           <= mispredict ? RECOVER : NORMAL;
      o_fb_valid      <= res_fire;
      o_recover_valid <= mispredict;
      if (res_fire) begin
        o_fb_pc         <= head.pc;
        o_fb_prediction <= head.prediction;
        o_fb_outcome    <= i_res_outcome;
      end
      if (mispredict) begin
        o_recover_target <= (i_res_outcome == TAKEN) ? head.target
                                                     : head.pc + ADDR_WIDTH'(8);
      end
      if (res_fire && !(&o_branch_count))
        o_branch_count <= o_branch_count + CNT_WIDTH'(1);
      if (mispredict && !(&o_mispredict_count))
        o_mispredict_count <= o_mispredict_count + CNT_WIDTH'(1);
      o_err <= o_err | res_err | push_err;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-computed expectations, immediate assertions.
module tb_branch_resolver;
  import mips_core_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  i_push_valid;
  logic [ADDR_WIDTH-1:0] i_push_pc;
  BranchOutcome          i_push_prediction;
  logic [ADDR_WIDTH-1:0] i_push_target;
  logic                  o_push_ready;
  logic                  i_res_valid;
  BranchOutcome          i_res_outcome;
  logic                  o_fb_valid;
  logic [ADDR_WIDTH-1:0] o_fb_pc;
  BranchOutcome          o_fb_prediction;
  BranchOutcome          o_fb_outcome;
  logic                  o_recover_valid;
  logic [ADDR_WIDTH-1:0] o_recover_target;
  logic [31:0]           o_branch_count;
  logic [31:0]           o_mispredict_count;
  logic                  o_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(4), .CNT_WIDTH(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_push_valid      (i_push_valid),
    .i_push_pc         (i_push_pc),
    .i_push_prediction (i_push_prediction),
    .i_push_target     (i_push_target),
    .o_push_ready      (o_push_ready),
    .i_res_valid       (i_res_valid),
    .i_res_outcome     (i_res_outcome),
    .o_fb_valid        (o_fb_valid),
    .o_fb_pc           (o_fb_pc),
    .o_fb_prediction   (o_fb_prediction),
    .o_fb_outcome      (o_fb_outcome),
    .o_recover_valid   (o_recover_valid),
    .o_recover_target  (o_recover_target),
    .o_branch_count    (o_branch_count),
    .o_mispredict_count(o_mispredict_count),
    .o_err             (o_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [31:0] pc, input BranchOutcome pred,
                          input logic [31:0] tgt);
    i_push_valid      = v;
    i_push_pc         = pc;
    i_push_prediction = pred;
    i_push_target     = tgt;
  endtask

  task automatic set_res(input logic v, input BranchOutcome oc);
    i_res_valid   = v;
    i_res_outcome = oc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_push(1'b0, 32'h0, NOT_TAKEN, 32'h0);
    set_res(1'b0, NOT_TAKEN);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // reset state
    chk("rst_fb_valid", o_fb_valid, 1'b0);
    chk("rst_recover", o_recover_valid, 1'b0);
    chk("rst_fb_pc", o_fb_pc, 32'h0);
    chk("rst_fb_pred", o_fb_prediction, NOT_TAKEN);
    chk("rst_fb_out", o_fb_outcome, NOT_TAKEN);
    chk("rst_rec_tgt", o_recover_target, 32'h0);
    chk("rst_bcount", o_branch_count, 32'd0);
    chk("rst_mcount", o_mispredict_count, 32'd0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_ready", o_push_ready, 1'b1);

    // correct not-taken resolve
    set_push(1'b1, 32'h100, NOT_TAKEN, 32'h200); tick();
    set_push(1'b0, 32'h0, NOT_TAKEN, 32'h0);
    set_res(1'b1, NOT_TAKEN); tick();
    set_res(1'b0, NOT_TAKEN);
    chk("ok_fb_valid", o_fb_valid, 1'b1);
    chk("ok_fb_pc", o_fb_pc, 32'h100);
    chk("ok_fb_pred", o_fb_prediction, NOT_TAKEN);
    chk("ok_fb_out", o_fb_outcome, NOT_TAKEN);
    chk("ok_recover", o_recover_valid, 1'b0);
    chk("ok_bcount", o_branch_count, 32'd1);
    chk("ok_mcount", o_mispredict_count, 32'd0);
    tick();
    chk("ok_fb_drop", o_fb_valid, 1'b0);

    // predicted NT, actually taken -> redirect to stored target
    set_push(1'b1, 32'h100, NOT_TAKEN, 32'h200); tick();
    set_push(1'b0, 32'h0, NOT_TAKEN, 32'h0);
    set_res(1'b1, TAKEN); tick();
    set_res(1'b0, NOT_TAKEN);
    chk("mp1_recover", o_recover_valid, 1'b1);
    chk("mp1_target", o_recover_target, 32'h200);
    chk("mp1_ready", o_push_ready, 1'b0);
    chk("mp1_fb_out", o_fb_outcome, TAKEN);
    chk("mp1_mcount", o_mispredict_count, 32'd1);
    chk("mp1_bcount", o_branch_count, 32'd2);
    tick();
    chk("mp1_rec_end", o_recover_valid, 1'b0);
    chk("mp1_ready_back", o_push_ready, 1'b1);

    // predicted taken, actually NT -> fall through to pc+8
    set_push(1'b1, 32'h300, TAKEN, 32'h400); tick();
    set_push(1'b0, 32'h0, NOT_TAKEN, 32'h0);
    set_res(1'b1, NOT_TAKEN); tick();
    set_res(1'b0, NOT_TAKEN);
    chk("mp2_recover", o_recover_valid, 1'b1);
    chk("mp2_target", o_recover_target, 32'h308);
    chk("mp2_mcount", o_mispredict_count, 32'd2);
    tick();
    chk("mp2_err", o_err, 1'b0);

    // fill, overflow push, push+resolve while full, drain across wrap
    for (int i = 1; i <= 4; i++) begin
      set_push(1'b1, 32'h10 * i, NOT_TAKEN, 32'h1000); tick();
    end
    set_push(1'b0, 32'h0, NOT_TAKEN, 32'h0);
    chk("full_ready", o_push_ready, 1'b0);
    chk("full_err0", o_err, 1'b0);
    set_push(1'b1, 32'h99, NOT_TAKEN, 32'h1000); tick();
    chk("ovf_err", o_err, 1'b1);
    set_push(1'b1, 32'h50, NOT_TAKEN, 32'h1000);
    set_res(1'b1, NOT_TAKEN); tick();
    set_push(1'b0, 32'h0, NOT_TAKEN, 32'h0);
    chk("pr_fb_pc", o_fb_pc, 32'h10);
    chk("pr_still_full", o_push_ready, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("drain_fb_pc", o_fb_pc, 32'h10 * i);
      chk("drain_fb_valid", o_fb_valid, 1'b1);
    end
    set_res(1'b0, NOT_TAKEN);
    chk("drain_bcount", o_branch_count, 32'd8);
    chk("drain_mcount", o_mispredict_count, 32'd2);
    chk("drain_ready", o_push_ready, 1'b1);

    // mispredict with a concurrent push; pushes during recovery are silent
    do_reset();
    chk("r2_err", o_err, 1'b0);
    set_push(1'b1, 32'h500, TAKEN, 32'h600); tick();
    set_push(1'b1, 32'h510, TAKEN, 32'h600); tick();
    set_push(1'b1, 32'h520, TAKEN, 32'h600); tick();
    set_push(1'b1, 32'h530, TAKEN, 32'h600);
    set_res(1'b1, NOT_TAKEN); tick();
    set_res(1'b0, NOT_TAKEN);
    set_push(1'b1, 32'h540, TAKEN, 32'h600);
    chk("fl_recover", o_recover_valid, 1'b1);
    chk("fl_target", o_recover_target, 32'h508);
    chk("fl_err", o_err, 1'b0);
    chk("fl_ready", o_push_ready, 1'b0);
    tick();
    set_push(1'b0, 32'h0, NOT_TAKEN, 32'h0);
    chk("fl_rec_push_err", o_err, 1'b0);
    chk("fl_ready_back", o_push_ready, 1'b1);
    set_res(1'b1, TAKEN); tick();
    set_res(1'b0, NOT_TAKEN);
    chk("fl_empty_err", o_err, 1'b1);
    chk("fl_empty_fb", o_fb_valid, 1'b0);
    chk("fl_bcount", o_branch_count, 32'd1);

    // reset mid-operation with feedback due
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h700 + 32'h10 * i, NOT_TAKEN, 32'h800); tick();
    end
    set_push(1'b0, 32'h0, NOT_TAKEN, 32'h0);
    set_res(1'b1, NOT_TAKEN); tick();
    chk("mr_pre_fb_pc", o_fb_pc, 32'h700);
    chk("mr_pre_bcount", o_branch_count, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mr_fb_valid", o_fb_valid, 1'b0);
    chk("mr_recover", o_recover_valid, 1'b0);
    chk("mr_bcount", o_branch_count, 32'd0);
    chk("mr_mcount", o_mispredict_count, 32'd0);
    chk("mr_ready", o_push_ready, 1'b1);
    rst_n = 1'b1;
    tick();
    set_res(1'b0, NOT_TAKEN);
    chk("mr_discarded_err", o_err, 1'b1);
    chk("mr_discarded_fb", o_fb_valid, 1'b0);

    // resolve during RECOVER is rejected
    do_reset();
    set_push(1'b1, 32'h800, NOT_TAKEN, 32'h900); tick();
    set_push(1'b0, 32'h0, NOT_TAKEN, 32'h0);
    set_res(1'b1, TAKEN); tick();
    chk("rc_target", o_recover_target, 32'h900);
    chk("rc_err0", o_err, 1'b0);
    tick();
    set_res(1'b0, NOT_TAKEN);
    chk("rc_err", o_err, 1'b1);
    chk("rc_fb", o_fb_valid, 1'b0);
    chk("rc_bcount", o_branch_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
